// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request at a time on the
// instruction bus and hands each returned word, with its PC, to IF/ID.
// Optional feature macro: FETCH_FAST_REISSUE_EN. When it is defined, a packet
// accepted by decode launches the next bus request in the same cycle.
module fetch_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ibus_req_valid,
    output logic [XLEN-1:0] ibus_req_addr,
    input  logic            ibus_addr_ok,
    input  logic            ibus_data_ok,
    input  logic [63:0]     ibus_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_exc
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            exc_q, exc_d;

    logic            issuing;
    logic [XLEN-1:0] req_pc;
    logic [31:0]     sel_word;

`ifdef FETCH_FAST_REISSUE_EN
    logic fast_issue;

    // A fired, non-exception packet with no redirect launches the next fetch at once
    always_comb begin
        fast_issue = (state_q == HOLD) && out_ready && !redirect_valid && !exc_q;
        issuing    = (state_q == REQ) || fast_issue;
        req_pc     = fast_issue ? pc_q + XLEN'(4) : pc_q;
    end
`else
    // Bus request is driven purely from registered state
    always_comb begin
        issuing = (state_q == REQ);
        req_pc  = pc_q;
    end
`endif

    // Pick the 32-bit half of the response doubleword addressed by the request PC
    always_comb begin
        sel_word = req_pc[2] ? ibus_data[63:32] : ibus_data[31:0];
    end

    // Bus and IF/ID outputs; zero whenever not valid
    always_comb begin
        ibus_req_valid = issuing;
        ibus_req_addr  = issuing ? req_pc : '0;
        out_valid      = (state_q == HOLD);
        out_pc         = out_valid ? pc_q : '0;
        out_instr      = out_valid ? instr_q : '0;
        out_exc        = out_valid && exc_q;
    end

    // Next-state, PC, pending-redirect and packet logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        instr_d   = instr_q;
        exc_d     = exc_q;
        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (pc_q[1:0] != 2'b00) begin
                    state_d = HOLD;
                    exc_d   = 1'b1;
                    instr_d = '0;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ibus_addr_ok) begin
                    // A redirect this cycle is newer than any pending one
                    if (redirect_valid || pend_q) begin
                        pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
                        pend_d  = 1'b0;
                        state_d = ibus_data_ok ? IDLE : DROP;
                    end else if (ibus_data_ok) begin
                        instr_d = sel_word;
                        exc_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (redirect_valid) begin
                    // Address must stay stable until accepted, so defer the redirect
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_pc;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ibus_data_ok ? IDLE : DROP;
                end else if (ibus_data_ok) begin
                    instr_d = sel_word;
                    exc_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (ibus_data_ok) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (exc_q) begin
                        // Misaligned PC is sticky until execute redirects
                        state_d = IDLE;
                    end else begin
                        pc_d = pc_q + XLEN'(4);
`ifdef FETCH_FAST_REISSUE_EN
                        // Request for pc+4 is already on the bus this cycle
                        if (ibus_addr_ok && ibus_data_ok) begin
                            instr_d = sel_word;
                            exc_d   = 1'b0;
                            state_d = HOLD;
                        end else if (ibus_addr_ok) begin
                            state_d = WAIT;
                        end else begin
                            state_d = REQ;
                        end
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            instr_q   <= '0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            instr_q   <= instr_d;
            exc_q     <= exc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle-by-cycle vector table plus a
// hand-written stall/release sequence. Honours FETCH_FAST_REISSUE_EN.
module tb_fetch_unit;

    localparam logic [63:0] B  = 64'h8000_0000;
    localparam logic [63:0] D1 = 64'h0000_0013_0000_0093;
    localparam logic [63:0] D2 = 64'hAAAA_BBBB_1111_2222;
    localparam logic [63:0] DX = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        ibus_req_valid;
    logic [63:0] ibus_req_addr;
    logic        ibus_addr_ok;
    logic        ibus_data_ok;
    logic [63:0] ibus_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(.XLEN(64), .RESET_PC(64'h8000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ibus_req_valid (ibus_req_valid),
        .ibus_req_addr  (ibus_req_addr),
        .ibus_addr_ok   (ibus_addr_ok),
        .ibus_data_ok   (ibus_data_ok),
        .ibus_data      (ibus_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_exc        (out_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, aok, dok;
        logic [63:0] data;
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        bit          chk, full;
        logic        erv;
        logic [63:0] eaddr;
        logic        eov;
        logic [63:0] epc;
        logic [31:0] einstr;
        logic        eexc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, aok, dok, input logic [63:0] data,
                       input logic rv, input logic [63:0] rpc, input logic rdy,
                       input bit chk, full, input logic erv, input logic [63:0] eaddr,
                       input logic eov, input logic [63:0] epc, input logic [31:0] einstr,
                       input logic eexc);
        vec_t v;
        v.rst = rst; v.aok = aok; v.dok = dok; v.data = data; v.rv = rv; v.rpc = rpc;
        v.rdy = rdy; v.chk = chk; v.full = full; v.erv = erv; v.eaddr = eaddr;
        v.eov = eov; v.epc = epc; v.einstr = einstr; v.eexc = eexc;
        vecs.push_back(v);
    endtask

    // Row expecting no bus request and no packet
    task automatic idle(input logic aok, dok, input logic [63:0] data,
                        input logic rv, input logic [63:0] rpc, input logic rdy);
        add(1'b0, aok, dok, data, rv, rpc, rdy, 1, 0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Row expecting a bus request at addr and no packet
    task automatic req(input logic aok, dok, input logic [63:0] data,
                       input logic rv, input logic [63:0] rpc, input logic rdy,
                       input logic [63:0] addr);
        add(1'b0, aok, dok, data, rv, rpc, rdy, 1, 0, 1'b1, addr, 1'b0, '0, '0, 1'b0);
    endtask

    // Row expecting a held packet and no bus request
    task automatic hold(input logic rv, input logic [63:0] rpc, input logic rdy,
                        input logic [63:0] pc, input logic [31:0] instr, input logic exc);
        add(1'b0, 1'b0, 1'b0, '0, rv, rpc, rdy, 1, 0, 1'b0, '0, 1'b1, pc, instr, exc);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, aok, dok, input logic [63:0] data,
                         input logic rv, input logic [63:0] rpc, input logic rdy);
        reset = rst; ibus_addr_ok = aok; ibus_data_ok = dok; ibus_data = data;
        redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    endtask

    initial begin
        bit seen;
        drive(1'b1, 0, 0, '0, 0, '0, 0);
        // reset, misc scenarios as per-cycle rows; outputs are those seen in that cycle
        add(1, 0, 0, '0, 0, '0, 0, 0, 0, 0, '0, 0, '0, '0, 0);
        add(1, 0, 0, '0, 0, '0, 0, 1, 1, 0, '0, 0, '0, '0, 0);
        add(0, 0, 0, '0, 0, '0, 0, 1, 1, 0, '0, 0, '0, '0, 0);
        req(1, 1, D1, 0, '0, 0, B);
`ifndef FETCH_FAST_REISSUE_EN
        hold(0, '0, 1, B, 32'h0000_0093, 0);
        idle(0, 0, '0, 0, '0, 0);
        req(1, 1, D1, 0, '0, 0, B + 4);
        hold(0, '0, 1, B + 4, 32'h0000_0013, 0);
        idle(0, 0, '0, 0, '0, 0);
        req(1, 0, '0, 0, '0, 0, B + 8);
        idle(0, 1, D2, 0, '0, 0);
        for (int i = 0; i < 5; i++) hold(0, '0, 0, B + 8, 32'h1111_2222, 0);
        hold(0, '0, 1, B + 8, 32'h1111_2222, 0);
        idle(0, 0, '0, 0, '0, 0);
        req(1, 0, '0, 0, '0, 0, B + 64'hC);
        idle(0, 0, '0, 1, B + 64'h100, 0);
        idle(0, 0, '0, 0, '0, 0);
        idle(0, 0, '0, 0, '0, 0);
        idle(0, 1, DX, 0, '0, 0);
        idle(0, 0, '0, 0, '0, 1);
        req(1, 1, 64'h0000_0000_0000_0513, 0, '0, 0, B + 64'h100);
        hold(0, '0, 1, B + 64'h100, 32'h0000_0513, 0);
        idle(0, 0, '0, 0, '0, 0);
        req(0, 0, '0, 1, B + 64'h200, 0, B + 64'h104);
        req(0, 0, '0, 0, '0, 0, B + 64'h104);
        req(0, 0, '0, 1, B + 64'h300, 0, B + 64'h104);
        req(0, 0, '0, 0, '0, 0, B + 64'h104);
        req(1, 0, '0, 0, '0, 0, B + 64'h104);
        idle(0, 1, DX, 0, '0, 0);
        idle(0, 0, '0, 0, '0, 0);
        req(1, 1, 64'h1234_5678_0010_0073, 0, '0, 0, B + 64'h300);
        hold(0, '0, 1, B + 64'h300, 32'h0010_0073, 0);
        idle(0, 0, '0, 0, '0, 0);
        req(1, 1, 64'h89AB_CDEF_0123_4567, 0, '0, 0, B + 64'h304);
        hold(1, B + 64'h102, 1, B + 64'h304, 32'h89AB_CDEF, 0);
        idle(0, 0, '0, 0, '0, 0);
        hold(0, '0, 1, B + 64'h102, 32'h0, 1);
        idle(0, 0, '0, 0, '0, 0);
        hold(1, B + 64'h400, 0, B + 64'h102, 32'h0, 1);
        idle(0, 0, '0, 0, '0, 0);
        req(1, 0, '0, 0, '0, 0, B + 64'h400);
        add(1, 0, 0, '0, 0, '0, 0, 1, 0, 0, '0, 0, '0, '0, 0);
        add(0, 0, 1, DX, 0, '0, 0, 1, 1, 0, '0, 0, '0, '0, 0);
        req(0, 0, '0, 0, '0, 0, B);
        req(1, 1, D1, 0, '0, 0, B);
        hold(0, '0, 1, B, 32'h0000_0093, 0);
        idle(0, 0, '0, 0, '0, 0);
        req(1, 1, DX, 1, B + 64'h500, 0, B + 4);
        idle(0, 0, '0, 0, '0, 0);
        req(1, 0, '0, 1, B + 64'h600, 0, B + 64'h500);
        idle(0, 1, DX, 0, '0, 0);
        idle(0, 0, '0, 0, '0, 0);
        req(0, 0, '0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, B + 64'h600);
        req(1, 1, DX, 0, '0, 0, B + 64'h600);
        idle(0, 0, '0, 0, '0, 0);
        req(1, 1, 64'h0000_00AA_0000_00BB, 0, '0, 0, 64'hFFFF_FFFF_FFFF_FFFC);
        hold(0, '0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_00AA, 0);
        idle(0, 0, '0, 0, '0, 0);
        req(0, 0, '0, 0, '0, 0, 64'h0);
`else
        add(0, 1, 0, '0, 0, '0, 1, 1, 0, 1, B + 4, 1, B, 32'h0000_0093, 0);
        idle(0, 1, D1, 0, '0, 0);
        hold(0, '0, 0, B + 4, 32'h0000_0013, 0);
        hold(0, '0, 0, B + 4, 32'h0000_0013, 0);
        add(0, 1, 1, D2, 0, '0, 1, 1, 0, 1, B + 8, 1, B + 4, 32'h0000_0013, 0);
        add(0, 0, 0, '0, 0, '0, 1, 1, 0, 1, B + 64'hC, 1, B + 8, 32'h1111_2222, 0);
        req(0, 0, '0, 0, '0, 0, B + 64'hC);
        req(1, 0, '0, 0, '0, 0, B + 64'hC);
        idle(0, 0, '0, 0, '0, 0);
        idle(0, 1, D2, 0, '0, 0);
        hold(1, B + 64'h700, 1, B + 64'hC, 32'hAAAA_BBBB, 0);
        idle(0, 0, '0, 0, '0, 0);
        req(0, 0, '0, 0, '0, 0, B + 64'h700);
`endif

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].aok, vecs[i].dok, vecs[i].data,
                  vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            #1;
            if (vecs[i].chk) begin
                check($sformatf("row%0d.req_valid", i), 64'(ibus_req_valid), 64'(vecs[i].erv));
                check($sformatf("row%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].eov));
                check($sformatf("row%0d.out_exc", i), 64'(out_exc), 64'(vecs[i].eexc));
                if (vecs[i].erv || vecs[i].full)
                    check($sformatf("row%0d.req_addr", i), ibus_req_addr, vecs[i].eaddr);
                if (vecs[i].eov || vecs[i].full) begin
                    check($sformatf("row%0d.out_pc", i), out_pc, vecs[i].epc);
                    check($sformatf("row%0d.out_instr", i), 64'(out_instr), 64'(vecs[i].einstr));
                end
            end
            @(negedge clk);
        end

        // Hand sequence: redirect from IDLE, bounded wait for request, stall then release
        drive(1'b1, 0, 0, '0, 0, '0, 0);
        @(negedge clk);
        drive(1'b0, 0, 0, '0, 1, B + 64'h800, 0);
        @(negedge clk);
        drive(1'b0, 0, 0, '0, 0, '0, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ibus_req_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("hs.req_seen", 64'(seen), 64'd1);
        check("hs.req_addr", ibus_req_addr, B + 64'h800);
        drive(1'b0, 1, 1, 64'h0000_0001_0000_0002, 0, '0, 0);
        @(negedge clk);
        drive(1'b0, 0, 0, '0, 0, '0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("hs.stall%0d.out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("hs.stall%0d.out_pc", i), out_pc, B + 64'h800);
            check($sformatf("hs.stall%0d.out_instr", i), 64'(out_instr), 64'h2);
            check($sformatf("hs.stall%0d.req_valid", i), 64'(ibus_req_valid), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("hs.fire.out_valid", 64'(out_valid), 64'd1);
`ifdef FETCH_FAST_REISSUE_EN
        check("hs.fire.req_valid", 64'(ibus_req_valid), 64'd1);
        check("hs.fire.req_addr", ibus_req_addr, B + 64'h804);
`else
        check("hs.fire.req_valid", 64'(ibus_req_valid), 64'd0);
`endif
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("hs.after.out_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
